// File: rtl/score_keeper.sv
// score_keeper: snake-game score tracker.
// Keeps the current and high score, drives the body length, flashes the final
// score for a fixed HOLD period after each game, then shows the high score.
// The displayed value is converted to BCD by a sequential shift-add-3 engine
// that publishes whole results only, so the display never shows a partial value.

module score_keeper #(
  parameter int SCORE_W     = 7,
  parameter int MAX_SCORE   = 50,
  parameter int DIGITS      = 2,
  parameter int HOLD_CYCLES = 30_000_000,
  parameter int FLASH_HALF  = 3_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  goodColl,
  input  logic                  badColl,
  output logic [SCORE_W-1:0]    length,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  blank,
  output logic                  bcd_busy,
  output logic                  isGameComplete,
  output logic                  newHigh
);

  // ---------------------------------------------------------------------------
  // Derived widths and constants
  // ---------------------------------------------------------------------------
  localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int FLASH_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam int BCD_W   = 4 * DIGITS;
  localparam int SCR_W   = SCORE_W + BCD_W;
  localparam int ITER_W  = $clog2(SCORE_W + 1);

  localparam logic [SCORE_W-1:0] MAX_S      = SCORE_W'(MAX_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);
  localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_HALF - 1);
  localparam logic [FLASH_W-1:0] FLASH_ONE  = FLASH_W'(1);
  localparam logic [ITER_W-1:0]  ITER_LAST  = ITER_W'(SCORE_W);
  localparam logic [ITER_W-1:0]  ITER_ONE   = ITER_W'(1);

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    HOLD      = 2'd1,
    SHOW_HIGH = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Game state
  // ---------------------------------------------------------------------------
  state_e               state_q, state_d;
  logic [SCORE_W-1:0]   curr_q, curr_d;
  logic [SCORE_W-1:0]   high_q, high_d;
  logic                 done_q, done_d;
  logic                 new_high_q, new_high_d;
  logic                 blank_q, blank_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [FLASH_W-1:0]   flash_cnt_q, flash_cnt_d;
  logic                 go_hold;

  // ---------------------------------------------------------------------------
  // BCD converter state
  // ---------------------------------------------------------------------------
  logic                 busy_q, busy_d;
  logic [ITER_W-1:0]    iter_q, iter_d;
  logic [SCR_W-1:0]     scratch_q, scratch_d;
  logic [SCORE_W-1:0]   sample_q, sample_d;
  logic [SCORE_W-1:0]   last_conv_q, last_conv_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [SCORE_W-1:0]   disp_d;

  // One shift-add-3 iteration: bump every BCD digit >= 5 by 3, then shift left.
  function automatic logic [SCR_W-1:0] dabble_step(input logic [SCR_W-1:0] s);
    logic [SCR_W-1:0] t;
    t = s;
    for (int d = 0; d < DIGITS; d++) begin
      if (t[SCORE_W+4*d +: 4] > 4'd4) begin
        t[SCORE_W+4*d +: 4] = t[SCORE_W+4*d +: 4] + 4'd3;
      end
    end
    return {t[SCR_W-2:0], 1'b0};
  endfunction

  // Game FSM: next state, score bookkeeping, hold timer and flash control.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    curr_d      = curr_q;
    high_d      = high_q;
    done_d      = done_q;
    new_high_d  = new_high_q;
    blank_d     = blank_q;
    hold_cnt_d  = hold_cnt_q;
    flash_cnt_d = flash_cnt_q;
    go_hold     = 1'b0;

    unique case (state_q)
      PLAY: begin
        if (badColl || curr_q >= MAX_S) begin
          // A hit ends the game with the score unchanged; badColl beats goodColl.
          go_hold = 1'b1;
        end else if (goodColl) begin
          // curr_q < MAX_S here, so the increment saturates at MAX_S.
          curr_d = curr_q + SCORE_ONE;
          if (curr_d == MAX_S) begin
            go_hold = 1'b1;
          end
        end
      end

      HOLD: begin
        // Collisions are ignored; score and length stay frozen.
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = SHOW_HIGH;
          curr_d  = '0;
          blank_d = 1'b0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
          if (flash_cnt_q == FLASH_LAST) begin
            blank_d     = ~blank_q;
            flash_cnt_d = '0;
          end else begin
            flash_cnt_d = flash_cnt_q + FLASH_ONE;
          end
        end
      end

      SHOW_HIGH: begin
        // Only food restarts the game; the first point counts immediately.
        if (goodColl) begin
          state_d    = PLAY;
          curr_d     = SCORE_ONE;
          done_d     = 1'b0;
          new_high_d = 1'b0;
        end
      end

      default: begin
        state_d = PLAY;
      end
    endcase

    // Game-over entry: latch the high score using the final score of this game.
    if (go_hold) begin
      state_d     = HOLD;
      done_d      = 1'b1;
      new_high_d  = (curr_d > high_q);
      high_d      = (curr_d > high_q) ? curr_d : high_q;
      blank_d     = 1'b0;
      hold_cnt_d  = '0;
      flash_cnt_d = '0;
    end
  end

  // Display value as it will be registered on this edge; the converter samples
  // it on the same edge the score changes, keeping display latency minimal.
  always_comb begin
    disp_d = (state_d == SHOW_HIGH) ? high_d : curr_d;
  end

  // BCD converter: sample when idle and stale, iterate SCORE_W times, publish.
  always_comb begin
    busy_d      = busy_q;
    iter_d      = iter_q;
    scratch_d   = scratch_q;
    sample_d    = sample_q;
    last_conv_d = last_conv_q;
    bcd_d       = bcd_q;

    if (!busy_q) begin
      if (disp_d != last_conv_q) begin
        busy_d    = 1'b1;
        iter_d    = '0;
        sample_d  = disp_d;
        scratch_d = {{BCD_W{1'b0}}, disp_d};
      end
    end else if (iter_q != ITER_LAST) begin
      scratch_d = dabble_step(scratch_q);
      iter_d    = iter_q + ITER_ONE;
    end else begin
      // Publish all digits at once, then chase any change seen meanwhile
      // without dropping busy.
      bcd_d       = scratch_q[SCR_W-1 -: BCD_W];
      last_conv_d = sample_q;
      busy_d      = 1'b0;
      if (disp_d != sample_q) begin
        busy_d    = 1'b1;
        iter_d    = '0;
        sample_d  = disp_d;
        scratch_d = {{BCD_W{1'b0}}, disp_d};
      end
    end
  end

  // State registers with synchronous reset back to an idle PLAY state.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= PLAY;
      curr_q      <= '0;
      high_q      <= '0;
      done_q      <= 1'b0;
      new_high_q  <= 1'b0;
      blank_q     <= 1'b0;
      hold_cnt_q  <= '0;
      flash_cnt_q <= '0;
      busy_q      <= 1'b0;
      iter_q      <= '0;
      scratch_q   <= '0;
      sample_q    <= '0;
      last_conv_q <= '0;
      bcd_q       <= '0;
    end else begin
      state_q     <= state_d;
      curr_q      <= curr_d;
      high_q      <= high_d;
      done_q      <= done_d;
      new_high_q  <= new_high_d;
      blank_q     <= blank_d;
      hold_cnt_q  <= hold_cnt_d;
      flash_cnt_q <= flash_cnt_d;
      busy_q      <= busy_d;
      iter_q      <= iter_d;
      scratch_q   <= scratch_d;
      sample_q    <= sample_d;
      last_conv_q <= last_conv_d;
      bcd_q       <= bcd_d;
    end
  end

  assign length         = curr_q;
  assign bcd            = bcd_q;
  assign blank          = blank_q;
  assign bcd_busy       = busy_q;
  assign isGameComplete = done_q;
  assign newHigh        = new_high_q;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed scenarios plus randomized
// collisions/resets, compared every cycle against a behavioural game model.

module tb_score_keeper;

  localparam int SCORE_W     = 7;
  localparam int MAX_SCORE   = 50;
  localparam int DIGITS      = 2;
  localparam int HOLD_CYCLES = 16;
  localparam int FLASH_HALF  = 4;
  localparam int CONV_LAT    = SCORE_W + 1;

  localparam int P_PLAY = 0;
  localparam int P_HOLD = 1;
  localparam int P_SHOW = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 goodColl;
  logic                 badColl;
  logic [SCORE_W-1:0]   length;
  logic [4*DIGITS-1:0]  bcd;
  logic                 blank;
  logic                 bcd_busy;
  logic                 isGameComplete;
  logic                 newHigh;

  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  int m_ph, m_sc, m_hi, m_done, m_nh, m_age;
  int m_busy, m_samp, m_last, m_left, m_bcd;

  score_keeper #(
    .SCORE_W    (SCORE_W),
    .MAX_SCORE  (MAX_SCORE),
    .DIGITS     (DIGITS),
    .HOLD_CYCLES(HOLD_CYCLES),
    .FLASH_HALF (FLASH_HALF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .goodColl      (goodColl),
    .badColl       (badColl),
    .length        (length),
    .bcd           (bcd),
    .blank         (blank),
    .bcd_busy      (bcd_busy),
    .isGameComplete(isGameComplete),
    .newHigh       (newHigh)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Decimal digits packed as BCD, computed arithmetically.
  function automatic int to_bcd(input int v);
    int r;
    int x;
    r = 0;
    x = v;
    for (int d = 0; d < DIGITS; d++) begin
      r = r | ((x % 10) << (4 * d));
      x = x / 10;
    end
    return r;
  endfunction

  task automatic end_game();
    m_ph   = P_HOLD;
    m_done = 1;
    m_nh   = (m_sc > m_hi) ? 1 : 0;
    if (m_sc > m_hi) m_hi = m_sc;
    m_age  = 0;
  endtask

  task automatic conv_start(input int v);
    m_busy = 1;
    m_samp = v;
    m_left = CONV_LAT;
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_step(input bit g, input bit b, input bit r);
    int disp;
    if (r) begin
      m_ph = P_PLAY; m_sc = 0; m_hi = 0; m_done = 0; m_nh = 0; m_age = 0;
      m_busy = 0; m_samp = 0; m_last = 0; m_left = 0; m_bcd = 0;
      return;
    end
    case (m_ph)
      P_PLAY: begin
        if (b) end_game();
        else if (g) begin
          if (m_sc < MAX_SCORE) m_sc++;
          if (m_sc == MAX_SCORE) end_game();
        end
      end
      P_HOLD: begin
        m_age++;
        if (m_age == HOLD_CYCLES) begin
          m_ph = P_SHOW;
          m_sc = 0;
        end
      end
      default: begin
        if (g) begin
          m_ph = P_PLAY; m_sc = 1; m_done = 0; m_nh = 0;
        end
      end
    endcase
    disp = (m_ph == P_SHOW) ? m_hi : m_sc;
    if (m_busy != 0) begin
      m_left--;
      if (m_left == 0) begin
        m_bcd  = to_bcd(m_samp);
        m_last = m_samp;
        m_busy = 0;
        if (disp != m_samp) conv_start(disp);
      end
    end else if (disp != m_last) begin
      conv_start(disp);
    end
  endtask

  task automatic compare_all();
    int exp_blank;
    exp_blank = (m_ph == P_HOLD) ? ((m_age / FLASH_HALF) % 2) : 0;
    check("length",  32'(length),         32'(m_sc));
    check("bcd",     32'(bcd),            32'(m_bcd));
    check("blank",   32'(blank),          32'(exp_blank));
    check("busy",    32'(bcd_busy),       32'(m_busy));
    check("done",    32'(isGameComplete), 32'(m_done));
    check("newhigh", 32'(newHigh),        32'(m_nh));
  endtask

  // One clock: drive on the falling edge, step model on the rising edge, sample after.
  task automatic tick(input bit g, input bit b, input bit r);
    @(negedge clk);
    goodColl = g;
    badColl  = b;
    rst      = r;
    @(posedge clk);
    model_step(g, b, r);
    #1;
    compare_all();
  endtask

  task automatic pulses(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      repeat (gap - 1) tick(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst      = 1'b1;
    goodColl = 1'b0;
    badColl  = 1'b0;

    // Reset state.
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    check("rst_length", 32'(length), 0);
    check("rst_bcd",    32'(bcd), 0);
    check("rst_done",   32'(isGameComplete), 0);

    // 1. 37 pulses spaced 10 clocks; BCD ready within 8 clocks of the last.
    pulses(36, 10);
    tick(1'b1, 1'b0, 1'b0);
    check("t1_length", 32'(length), 37);
    idle(8);
    check("t1_bcd",  32'(bcd), 32'h37);
    check("t1_done", 32'(isGameComplete), 0);

    // 2. Score 12, simultaneous good and bad collision.
    tick(1'b0, 1'b0, 1'b1);
    pulses(12, 3);
    tick(1'b1, 1'b1, 1'b0);
    check("t2_length",  32'(length), 12);
    check("t2_done",    32'(isGameComplete), 1);
    check("t2_newhigh", 32'(newHigh), 1);

    // 3. HOLD: flashing, collisions ignored, then SHOW_HIGH.
    for (int a = 1; a <= HOLD_CYCLES; a++) begin
      tick((a % 3) == 1, (a % 5) == 2, 1'b0);
      if (a == 4 || a == 12) check("t3_blank_on", 32'(blank), 1);
      if (a == 8)            check("t3_blank_off", 32'(blank), 0);
      if (a < HOLD_CYCLES)   check("t3_frozen", 32'(length), 12);
    end
    check("t3_show_length", 32'(length), 0);
    check("t3_show_blank",  32'(blank), 0);
    check("t3_show_done",   32'(isGameComplete), 1);
    idle(CONV_LAT + 1);
    check("t3_show_bcd", 32'(bcd), 32'h12);

    // 4. Win at 50, then a weaker game.
    tick(1'b1, 1'b0, 1'b0);
    check("t4_restart_len", 32'(length), 1);
    pulses(48, 2);
    idle(20);
    tick(1'b1, 1'b0, 1'b0);
    check("t4_win_len",  32'(length), 50);
    check("t4_win_done", 32'(isGameComplete), 1);
    idle(CONV_LAT);
    check("t4_hold_bcd", 32'(bcd), 32'h50);
    idle(HOLD_CYCLES - CONV_LAT);
    tick(1'b1, 1'b0, 1'b0);
    pulses(8, 3);
    idle(10);
    tick(1'b0, 1'b1, 1'b0);
    check("t4_lose_len",     32'(length), 9);
    check("t4_lose_newhigh", 32'(newHigh), 0);
    idle(HOLD_CYCLES + CONV_LAT);
    check("t4_show_bcd", 32'(bcd), 32'h50);

    // 5. Two pulses 2 clocks apart: 19 -> 20 -> 21, busy stays high.
    tick(1'b1, 1'b0, 1'b0);
    pulses(18, 3);
    idle(20);
    check("t5_start_bcd", 32'(bcd), 32'h19);
    tick(1'b1, 1'b0, 1'b0);
    check("t5_busy", 32'(bcd_busy), 1);
    for (int i = 1; i <= 2 * CONV_LAT; i++) begin
      tick(i == 2, 1'b0, 1'b0);
      check("t5_no_glitch", 32'(bcd == 8'h19 || bcd == 8'h20 || bcd == 8'h21), 1);
      if (i < 2 * CONV_LAT) check("t5_busy", 32'(bcd_busy), 1);
      if (i == CONV_LAT)    check("t5_bcd20", 32'(bcd), 32'h20);
    end
    check("t5_bcd21", 32'(bcd), 32'h21);
    check("t5_idle",  32'(bcd_busy), 0);

    // 6. Reset mid-HOLD and mid-conversion.
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    idle(2);
    check("t6_pre_busy", 32'(bcd_busy), 1);
    tick(1'b0, 1'b0, 1'b1);
    check("t6_length",  32'(length), 0);
    check("t6_bcd",     32'(bcd), 0);
    check("t6_blank",   32'(blank), 0);
    check("t6_busy",    32'(bcd_busy), 0);
    check("t6_done",    32'(isGameComplete), 0);
    check("t6_newhigh", 32'(newHigh), 0);
    tick(1'b1, 1'b0, 1'b0);
    check("t6_len1", 32'(length), 1);
    idle(CONV_LAT);
    check("t6_bcd1", 32'(bcd), 32'h01);

    // Randomized play, checked every cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 2) == 0, $urandom_range(0, 59) == 0,
           $urandom_range(0, 399) == 0);
    end
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 1) == 0, $urandom_range(0, 299) == 0,
           $urandom_range(0, 999) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
